digest_unpacker: RTL and testbench
==================================

Name: digest_unpacker

Overview:
- Output-side counterpart of the Keccak input padder: takes the c/2-bit digest from the f_permutation core in one parallel transfer and streams it to the user as IW-bit words under a valid/ack handshake.
- Sits between the f_permutation digest output and the integrity checker or any other hash consumer.
- Holds exactly one digest.
- Word order is most-significant chunk first, the mirror of the padder's shift-in order.

Parameters:
f, 1600, Keccak state width in bits
c, 1024, capacity in bits; localparam c2 = c/2 is the digest width (512)
IW, 64, output word width; c2 must be an exact multiple of IW; localparam NChunk = c2/IW (8)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in  input  c2  digest from f_permutation
in_ready  input  1  digest on "in" is valid; held until in_ack
in_ack  output  1  combinational; digest captured at this clock edge
out  output  IW  current output word = top IW bits of the holding register
out_valid  output  1  "out" holds a valid word
out_last  output  1  "out" is word NChunk-1 of the digest; only meaningful while out_valid=1
out_ack  input  1  user consumes the current word at this edge; ignored when out_valid=0
busy  output  1  equals out_valid; a digest is being drained

Behaviour:
- Storage:
  - buf [c2-1:0] holding register.
  - cnt, a clog2(NChunk)-bit word counter.
  - One state bit: IDLE or SEND.
- Reset (synchronous, active-high):
  - Next edge: state=IDLE, cnt=0, buf=0.
  - Hence out=0, out_valid=0, out_last=0, in_ack=0 while IDLE with in_ready=0.
  - Reset mid-drain discards the remaining words; no further out_valid until a new capture.
  - Reset dominates a coincident in_ready or out_ack.
- take = out_valid & out_ack.
- in_ack = in_ready & (state==IDLE | (take & out_last)). in_ack is never asserted while reset=1.
- IDLE:
  - out_valid=0.
  - On in_ack: buf<=in, cnt<=0, state<=SEND.
  - out_valid rises the next cycle with out=in[c2-1:c2-IW]. Capture-to-first-word latency is 1 cycle.
- SEND:
  - out_valid=1; out=buf[c2-1:c2-IW]; out_last=(cnt==NChunk-1).
  - On take with out_last=0: buf<=buf<<IW (zero fill), cnt<=cnt+1.
  - On take with out_last=1 and in_ready=0: state<=IDLE, cnt<=0.
  - On take with out_last=1 and in_ready=1: back-to-back capture; buf<=in, cnt<=0, stay in SEND. No bubble cycle.
  - Without take, all state holds; out and out_last stay stable while stalled.
- Throughput: one word per cycle with out_ack held high. A full digest needs NChunk acked cycles.
- in_ready while in SEND and not on the last take: no ack. The producer must hold "in" stable until in_ack.
- cnt never wraps inside a digest; it is reloaded to 0 on every capture.

Decomposition:
- Shared keccak package holds default f, c, IW and the derived c2 and NChunk constants, so padder, f_permutation and this block agree on widths.
- Package also holds the elaboration check that c2 % IW == 0.
- No sub-module. The block is one FSM plus a shift register, in a single file.

Test Plan:
- Single digest, out_ack tied 1:
  - Stimulus: in=512'h00..01_02..08 with chunk k = 64'h(k+1) at the top, in_ready one cycle.
  - Response: in_ack=1 that cycle; next 8 cycles out = 1,2,...,8; out_last only on the 8th word; then out_valid=0.
- Stall:
  - Stimulus: drop out_ack for 3 cycles after word 2.
  - Response: out stays 64'h3 and out_valid=1 through the stall; word count is still 8; out_last=1 only on the word 64'h8.
- Back-to-back:
  - Stimulus: second digest (chunks 64'hA0..A7) in_ready held from word 5 of the first.
  - Response: in_ack=0 until the last word's take; in_ack=1 in the same cycle as that take; the next cycle out=64'hA0 with no out_valid gap.
- Reset mid-drain:
  - Stimulus: assert reset after word 3 is taken.
  - Response: the next cycle out_valid=0, out=0, busy=0; a new digest afterwards starts again at its chunk 0.
- Idle robustness:
  - Stimulus: out_ack=1 while IDLE with no digest.
  - Response: no state change, out_valid stays 0.
- Reset priority:
  - Stimulus: in_ready=1 with reset=1.
  - Response: in_ack=0 and no capture.

Source files
------------

// File: rtl/digest_unpacker_pkg.sv
// Shared Keccak width constants so the padder, f_permutation and the digest
// unpacker all agree on state, capacity and word sizes.
package digest_unpacker_pkg;

    localparam int KeccakF  = 1600;
    localparam int KeccakC  = 1024;
    localparam int KeccakIW = 64;
    localparam int KeccakC2 = KeccakC / 2;
    localparam int NChunk   = KeccakC2 / KeccakIW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpackState_e;

    // A digest must split into whole output words and fit inside the state.
    function automatic bit widthsConsistent(input int f, input int c, input int iw);
        return (iw > 0) && (c < f) && (((c / 2) % iw) == 0);
    endfunction

    localparam bit DefaultWidthsOk = widthsConsistent(KeccakF, KeccakC, KeccakIW);

endpackage

// File: rtl/digest_unpacker.sv
// Takes one c/2-bit digest in a single parallel transfer and streams it out
// as IW-bit words, most-significant chunk first, under a valid/ack handshake.
module digest_unpacker
    import digest_unpacker_pkg::*;
#(
    parameter int f  = KeccakF,
    parameter int c  = KeccakC,
    parameter int IW = KeccakIW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [c/2-1:0] in,
    input  logic          in_ready,
    output logic          in_ack,
    output logic [IW-1:0] out,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ack,
    output logic          busy
);

    localparam int c2      = c / 2;
    localparam int NWords  = c2 / IW;
    localparam int CntW    = (NWords > 1) ? $clog2(NWords) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NWords - 1);

    if (!widthsConsistent(f, c, IW)) begin : g_badWidths
        $error("digest_unpacker: c/2 must be a multiple of IW and c < f");
    end

    unpackState_e    state_q, state_d;
    logic [c2-1:0]   buf_q, buf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            take;

    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    assign out       = buf_q[c2-1 -: IW];
    assign out_last  = out_valid && (cnt_q == LastCnt);
    assign take      = out_valid && out_ack;

    // A new digest is accepted when empty, or on the take of the final word so
    // that back-to-back digests stream with no bubble; reset blocks capture.
    assign in_ack = in_ready && !reset && ((state_q == IDLE) || (take && out_last));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        if (in_ack) begin
            buf_d   = in;
            cnt_d   = '0;
            state_d = SEND;
        end else if (take) begin
            if (out_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                buf_d = buf_q << IW;
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_digest_unpacker.sv
// Randomised and directed bench for digest_unpacker, checked against a
// word-queue model of the digest stream.
module tb_digest_unpacker;

    localparam int C2 = 512;
    localparam int IW = 64;
    localparam int NW = C2 / IW;

    logic          clk = 1'b0;
    logic          reset;
    logic [C2-1:0] din;
    logic          in_ready;
    logic          in_ack;
    logic [IW-1:0] dout;
    logic          out_valid;
    logic          out_last;
    logic          out_ack;
    logic          busy;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] expQ[$];
    bit            outZero;

    digest_unpacker dut (
        .clk      (clk),
        .reset    (reset),
        .in       (din),
        .in_ready (in_ready),
        .in_ack   (in_ack),
        .out      (dout),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ack  (out_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [IW-1:0] observed,
                               input logic [IW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [C2-1:0] makeDigest(input logic [IW-1:0] base);
        logic [C2-1:0] d;
        d = '0;
        for (int k = 0; k < NW; k++) d[C2-1-k*IW -: IW] = base + IW'(k);
        return d;
    endfunction

    // Drives one cycle of inputs, checks outputs mid-cycle against the queue
    // model, then advances the model on the clock edge.
    task automatic applyStimulus(input bit rst, input bit rdy, input bit ack,
                                 input logic [C2-1:0] d, output bit accepted);
        bit expValid, expLast, expTake, expInAck;
        reset = rst; in_ready = rdy; out_ack = ack; din = d;
        @(negedge clk);
        expValid = (expQ.size() > 0);
        expLast  = (expQ.size() == 1);
        expTake  = expValid && ack;
        expInAck = rdy && !rst && (!expValid || (expTake && expLast));
        checkOutput("out_valid", IW'(out_valid), IW'(expValid));
        checkOutput("busy", IW'(busy), IW'(expValid));
        checkOutput("in_ack", IW'(in_ack), IW'(expInAck));
        if (expValid) begin
            checkOutput("out", dout, expQ[0]);
            checkOutput("out_last", IW'(out_last), IW'(expLast));
        end else if (outZero) begin
            checkOutput("out_idle", dout, '0);
        end
        @(posedge clk);
        if (rst) begin
            expQ.delete();
            outZero = 1'b1;
        end else begin
            if (expTake) void'(expQ.pop_front());
            if (expInAck) begin
                for (int k = 0; k < NW; k++) expQ.push_back(d[C2-1-k*IW -: IW]);
                outZero = 1'b0;
            end
        end
        accepted = expInAck;
        #1;
    endtask

    initial begin
        logic [C2-1:0] d1, d2, pendD;
        bit acc, pending, rst, ack;

        d1 = makeDigest(64'h1);
        d2 = makeDigest(64'hA0);
        reset = 1'b1; in_ready = 1'b0; out_ack = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        outZero = 1'b1;

        // Single digest with out_ack held high.
        applyStimulus(0, 1, 1, d1, acc);
        for (int i = 0; i < NW + 1; i++) applyStimulus(0, 0, 1, '0, acc);

        // Stall for three cycles after the second word.
        applyStimulus(0, 1, 1, d1, acc);
        repeat (2) applyStimulus(0, 0, 1, '0, acc);
        repeat (3) applyStimulus(0, 0, 0, '0, acc);
        repeat (7) applyStimulus(0, 0, 1, '0, acc);

        // Back-to-back: second digest offered from word 5 of the first.
        applyStimulus(0, 1, 1, d1, acc);
        repeat (4) applyStimulus(0, 0, 1, '0, acc);
        repeat (4) applyStimulus(0, 1, 1, d2, acc);
        repeat (NW + 1) applyStimulus(0, 0, 1, '0, acc);

        // Reset after word 3 is taken, then a fresh digest.
        applyStimulus(0, 1, 1, d2, acc);
        repeat (3) applyStimulus(0, 0, 1, '0, acc);
        applyStimulus(1, 0, 1, '0, acc);
        repeat (2) applyStimulus(0, 0, 1, '0, acc);
        applyStimulus(0, 1, 1, d1, acc);
        repeat (NW + 1) applyStimulus(0, 0, 1, '0, acc);

        // Idle robustness and reset priority over a pending digest.
        repeat (3) applyStimulus(0, 0, 1, '0, acc);
        applyStimulus(1, 1, 1, d1, acc);
        repeat (2) applyStimulus(0, 0, 1, '0, acc);

        // Random producer/consumer traffic; the producer holds its digest until accepted.
        pending = 1'b0;
        pendD   = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pending && ($urandom_range(0, 3) == 0)) begin
                pending = 1'b1;
                for (int k = 0; k < C2 / 32; k++) pendD[k*32 +: 32] = $urandom;
            end
            ack = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 120) == 0);
            applyStimulus(rst, pending, ack, pending ? pendD : '0, acc);
            if (acc) pending = 1'b0;
        end
        repeat (NW + 2) applyStimulus(0, 0, 1, '0, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
